xc_aessub: RTL
==============

XC_AESSUB -- requirements
Module: xc_aessub

Interface
- REQ-001: The block SHALL have no parameters.
- REQ-002: clock  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: reset  input  1  asynchronous, active-high reset.
- REQ-004: valid  input  1  request is present; held high until ready is seen.
- REQ-005: rs1  input  32  source register 1; supplies t0=rs1[7:0] and t1=rs1[15:8].
- REQ-006: rs2  input  32  source register 2; supplies t2=rs2[23:16] and t3=rs2[31:24].
- REQ-007: enc  input  32  nonzero selects forward S-box (encrypt); zero selects inverse S-box (decrypt).
- REQ-008: ready  output  1  one-cycle pulse; result is valid in that cycle.
- REQ-009: result  output  32  {S(t3),S(t2),S(t1),S(t0)}, byte-packed in the form the downstream xc_aesmix consumes.

Function
- REQ-010: S SHALL be the FIPS-197 SubBytes S-box when enc!=0, and InvSubBytes when enc==0.
- REQ-011: A single shared S-box instance SHALL be time-multiplexed, one byte per cycle.
- REQ-012: The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
- REQ-013: IDLE with valid=1: capture t0..t3 and the enc-is-nonzero bit into registers; clear the 2-bit byte index; next state BUSY.
- REQ-014: IDLE with valid=0: remain in IDLE.
- REQ-015: BUSY: write S(captured byte[index]) into result byte[index]; increment the index; go to DONE when index==3, otherwise stay in BUSY.
- REQ-016: DONE: drive ready=1 for exactly one cycle; next state IDLE unconditionally.
- REQ-017: Latency SHALL be fixed. If valid is first seen high in IDLE in cycle N, ready SHALL be 1 in cycle N+5.
- REQ-018: Captured operands SHALL be used, so input changes after the capture cycle SHALL NOT affect result.
- REQ-019: Abort: valid=0 in any BUSY cycle SHALL return the FSM to IDLE next cycle, with no ready pulse; partial result bytes are don't-care.
- REQ-020: result SHALL hold its value from DONE until the next BUSY write; it need not be masked outside ready.
- REQ-021: valid still high in the IDLE cycle after DONE SHALL start a new operation; back-to-back operations have a 6-cycle period.
- REQ-022: ready SHALL never be asserted in IDLE or BUSY.
- REQ-023: The index SHALL wrap 3->0 only through the IDLE capture step, never inside BUSY.

Reset
- REQ-024: Asserting reset SHALL immediately force state=IDLE, index=0, ready=0 and result=32'h0.
- REQ-025: Reset asserted mid-operation SHALL discard that operation with no ready pulse.
- REQ-026: The first operation after reset deassertion SHALL obey REQ-017 exactly.

Structure
- REQ-027: A shared package SHALL hold:
  - the FSM state encodings (IDLE, BUSY, DONE);
  - the GF(2^8) reduction constant 8'h1b;
  - the affine constant 8'h63 and the inverse-affine constant 8'h05.
- REQ-028: One combinational sub-module, xc_aessub_sbox, SHALL implement the S-box:
  - ports: 8-bit in, 1-bit fwd, 8-bit out;
  - datapath: GF(2^8) inversion plus forward/inverse affine, with no lookup ROM.
- REQ-029: The formal bench SHALL compare the block against a golden model with combinational ready=valid, using the same stability assumptions as the aesmix bench.

Verification
- REQ-030: Forward, rs1=32'h0000_5300, rs2=32'h0153_0000, enc=1:
  - ready=1 exactly 5 cycles after valid rises;
  - result=32'h7CED_ED63.
- REQ-031: Inverse, rs1=32'h0000_ED63, rs2=32'h7C00_0000, enc=0 -> result=32'h0152_5300.
- REQ-032: Abort: valid dropped in the 2nd BUSY cycle -> no ready pulse; a fresh request then completes with correct result at N+5.
- REQ-033: Reset asserted in the 3rd BUSY cycle:
  - ready=0 and result=32'h0 immediately;
  - FSM in IDLE after reset releases.
- REQ-034: Back-to-back: valid held high across two requests (enc=1, then enc=0, operands all 32'h0):
  - ready pulses 6 cycles apart;
  - results 32'h6363_6363, then 32'h5252_5252.
- REQ-035: Operands changed during BUSY after capture -> result still reflects the captured values.

Source files
------------

// File: rtl/xc_aessub_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES SubBytes unit.
package xc_aessub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] GF_POLY   = 8'h1b;
  localparam logic [7:0] AFF_C     = 8'h63;
  localparam logic [7:0] INV_AFF_C = 8'h05;

  // Multiply modulo x^8+x^4+x^3+x+1 (shift-and-add).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    return (a << n) | (a >> (8 - n));
  endfunction

endpackage

// File: rtl/xc_aessub_sbox.sv
// Combinational AES S-box (fwd_i=1) or inverse S-box (fwd_i=0), no lookup ROM.
// Inverse is computed as x^254, so 0 maps to 0 without a special case.
module xc_aessub_sbox
  import xc_aessub_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       fwd_i,
  output logic [7:0] byte_o
);

  logic [7:0] pre, x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv, aff;

  // Decrypt undoes the affine map before inverting; encrypt applies it after.
  assign pre = fwd_i ? byte_i
                     : (rotl8(byte_i, 1) ^ rotl8(byte_i, 3) ^ rotl8(byte_i, 6) ^ INV_AFF_C);

  assign x2   = gf_mul(pre, pre);
  assign x3   = gf_mul(x2, pre);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x14  = gf_mul(x12, x2);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign inv  = gf_mul(x240, x14);

  assign aff = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ AFF_C;

  assign byte_o = fwd_i ? aff : inv;

endmodule

// File: rtl/xc_aessub.sv
// Byte-serial AES SubBytes on {rs2[31:24],rs2[23:16],rs1[15:8],rs1[7:0]}; ready pulses 5 cycles after capture.
// Requester holds valid until ready; dropping valid while busy aborts the operation.
module xc_aessub
  import xc_aessub_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] enc,
  output logic        ready,
  output logic [31:0] result
);

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [1:0]      idx_d;
  logic [3:0][7:0] bytes_q;
  logic [3:0][7:0] result_q;
  logic            fwd_q;
  logic            ready_q;
  logic [7:0]      sub_d;
  logic            unused_ops;

  assign unused_ops = ^{rs1[31:16], rs2[15:0]};

  xc_aessub_sbox u_sbox (
    .byte_i (bytes_q[idx_q]),
    .fwd_i  (fwd_q),
    .byte_o (sub_d)
  );

  // Index saturates at 3 inside BUSY; only the IDLE capture resets it.
  assign idx_d = (idx_q == 2'd3) ? idx_q : idx_q + 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      bytes_q  <= '0;
      result_q <= '0;
      fwd_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            bytes_q <= {rs2[31:24], rs2[23:16], rs1[15:8], rs1[7:0]};
            fwd_q   <= |enc;
            idx_q   <= 2'd0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!valid) begin
            state_q <= ST_IDLE;
          end else begin
            result_q[idx_q] <= sub_d;
            idx_q           <= idx_d;
            if (idx_q == 2'd3) begin
              state_q <= ST_DONE;
              ready_q <= 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule
